imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the CPU's 4096-word instruction RAM.
- Receives a framed byte stream from a host link (UART RX or test harness) and assembles little-endian 32-bit words.
- Writes each word to sequential RAM addresses starting at 0.
- Holds the CPU in reset during loading; releases it only after a valid checksum.

Parameters:
ADDR_W, 12, instruction RAM word-address width (depth 2**ADDR_W)
SYNC_BYTE, 8'hA5, frame start marker
BOOT_RUN, 0, 1 = release CPU after reset without a load (program preloaded from file)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte (transfer when in_valid && in_ready)
mem_we  out  1  RAM write request, held until mem_ready
mem_ready  in  1  RAM accepts write this cycle
mem_addr  out  ADDR_W  RAM word address
mem_wdata  out  32  RAM write data
cpu_rst_n  out  1  active-low reset to CPU
busy  out  1  frame in progress (state CNT_LO..CSUM)
done  out  1  last frame loaded OK (sticky until next SYNC_BYTE or rst)
err  out  1  last frame rejected (sticky until next SYNC_BYTE or rst)
words_loaded  out  ADDR_W+1  words written in current/last frame

Behaviour:
- Reset values: state IDLE; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; done=0; err=0; words_loaded=0; cpu_rst_n=BOOT_RUN; in_ready=1 after rst deasserts.
- All outputs registered. in_ready = !mem_we.
- States: IDLE, CNT_LO, CNT_HI, DATA, CSUM, RUN, ERR.
- IDLE: non-sync bytes are consumed and discarded. SYNC_BYTE -> CNT_LO; cpu_rst_n=0; done=err=0; words_loaded=0; mem_addr=0.
- CNT_LO/CNT_HI: 16-bit word count, low byte first.
  - Count 0 or count > 2**ADDR_W -> ERR (checked when the CNT_HI byte is accepted).
  - Otherwise -> DATA.
- DATA:
  - Bytes shift into the word LSB-first; 2-bit byte counter; 8-bit running sum of all payload bytes (mod 256).
  - On the 4th byte: next cycle mem_we=1, mem_wdata=word, mem_addr=current address.
  - mem_we holds with stable addr/data until the cycle mem_ready=1. mem_we falls the next cycle; mem_addr++ and words_loaded++ then.
  - in_ready=0 throughout, so at least one bubble per word.
  - After the last word's write completes -> CSUM.
- CSUM: one byte. Pass if (sum + byte) mod 256 == 0 -> RUN, done=1, cpu_rst_n=1 the cycle after acceptance. Fail -> ERR, err=1, cpu_rst_n stays 0.
- RUN/ERR: bytes still accepted. SYNC_BYTE restarts the frame exactly as from IDLE (cpu_rst_n drops the next cycle). Other bytes are discarded.
- SYNC_BYTE inside CNT/DATA/CSUM is ordinary data, not a resync.
- mem_addr wraps never: the count check bounds it, and the final address is 2**ADDR_W-1 at most.
- rst mid-frame or mid-write: mem_we drops immediately (next edge), all counters clear, partial word is lost, cpu_rst_n=BOOT_RUN.
- Simultaneous in_valid and pending mem_we: byte is not accepted (in_ready=0); upstream must hold it.

Decomposition:
- Package imem_loader_pkg:
  - state enum loader_state_t (7 states);
  - SYNC_BYTE default;
  - COUNT_W=16 constant.
- One sub-module is natural: loader_word_asm, holding the byte shifter, 2-bit byte counter and checksum accumulator.
- FSM, address counter and write handshake stay in the top.

Test Plan:
- Single word, mem_ready tied 1. Stream A5 01 00 13 00 00 00 ED -> one mem_we pulse, addr 0, data 32'h00000013. Then cpu_rst_n=1, done=1, err=0, words_loaded=1.
- Two words with mem_ready held low 3 cycles on the first write. Stream A5 02 00 + payload + csum -> mem_we held 4 cycles with stable addr 0/data, in_ready=0 throughout. Second write to addr 1; done=1.
- Bad checksum: A5 01 00 13 00 00 00 00 -> err=1, done=0, cpu_rst_n stays 0. A following valid frame -> err clears, done=1.
- Count 0 (A5 00 00) and count 4097 (A5 01 10) -> ERR right after the count bytes, no mem_we.
- Garbage 00 FF 12 before A5 is ignored. A5 inside payload is treated as data. A5 received in RUN drops cpu_rst_n and restarts at addr 0.
- rst asserted while mem_we=1 mid-frame -> next cycle mem_we=0, busy=0, words_loaded=0. With BOOT_RUN=1, cpu_rst_n=1 after reset.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM program loader.
package imem_loader_pkg;

  // Width of the frame word-count field carried in the stream header.
  localparam int COUNT_W = 16;

  // Frame start marker used when the top is not overridden.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Loader FSM states; busy covers CNT_LO through CSUM.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } loader_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Payload assembler: shifts bytes into a little-endian 32-bit word,
// counts bytes within the word and keeps the 8-bit running payload sum.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,       // start of a new frame
  input  logic        byte_valid_i,  // payload byte accepted this cycle
  input  logic [7:0]  byte_i,
  output logic        word_done_o,   // this byte completes a word
  output logic [31:0] word_o,        // word including the current byte
  output logic [7:0]  sum_o          // sum of payload bytes accepted so far
);

  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [1:0]  cnt_q;
  logic [7:0]  sum_q;

  // Each lane takes the lane above it; the top lane takes the new byte,
  // so after four bytes the first one received sits in bits [7:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_in;
      if (gi == 3) begin : g_top
        assign lane_in = byte_i;
      end else begin : g_mid
        assign lane_in = shift_q[8*(gi+1) +: 8];
      end
      assign shift_d[8*gi +: 8] = byte_valid_i ? lane_in : shift_q[8*gi +: 8];
    end
  endgenerate

  assign word_done_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o      = shift_d;
  assign sum_o       = sum_q;

  // Shifter, byte counter and checksum accumulator state.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 2'd1;
      sum_q   <= sum_q + byte_i;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses A5-framed images, writes words to the
// instruction RAM with a held write request, and gates the CPU reset on a
// valid trailing checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter logic       BOOT_RUN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest legal frame fills the RAM exactly.
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(1) << ADDR_W;

  loader_state_t       state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                in_ready_q, in_ready_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic                accept;
  logic                is_sync;
  logic [COUNT_W-1:0]  cnt_full;
  logic [ADDR_W:0]     words_inc;
  logic [7:0]          csum_total;
  logic                asm_clear;
  logic                asm_valid;
  logic                asm_word_done;
  logic [31:0]         asm_word;
  logic [7:0]          asm_sum;

  loader_word_asm u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_done_o  (asm_word_done),
    .word_o       (asm_word),
    .sum_o        (asm_sum)
  );

  assign accept     = in_valid && in_ready_q;
  assign is_sync    = (in_data == SYNC_BYTE);
  assign cnt_full   = {in_data, count_q[7:0]};
  assign words_inc  = words_q + 1'b1;
  assign csum_total = asm_sum + in_data;

  // Frame FSM, write handshake and address/word counters.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    words_d     = words_q;
    count_d     = count_q;
    asm_clear   = 1'b0;
    asm_valid   = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        // Only the sync byte matters here; everything else is dropped.
        if (accept && is_sync) begin
          state_d     = S_CNT_LO;
          cpu_rst_n_d = 1'b0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          words_d     = '0;
          mem_addr_d  = '0;
          asm_clear   = 1'b1;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          count_d = cnt_full;
          if (cnt_full == '0 || cnt_full > MAX_COUNT) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // accept and a pending write are mutually exclusive via in_ready.
        if (accept) begin
          asm_valid = 1'b1;
          if (asm_word_done) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = asm_word;
          end
        end
        if (mem_we_q && mem_ready) begin
          mem_we_d   = 1'b0;
          mem_addr_d = mem_addr_q + 1'b1;
          words_d    = words_inc;
          if (COUNT_W'(words_inc) == count_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (csum_total == 8'd0) begin
            state_d     = S_RUN;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d == S_CNT_LO) || (state_d == S_CNT_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
    in_ready_d = !mem_we_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= BOOT_RUN;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      in_ready_q  <= 1'b1;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed byte streams with hand-computed
// words and checksums, RAM back-pressure and mid-write reset.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              mem_ready;

  logic              in_ready, mem_we, cpu_rst_n, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  logic              b_in_ready, b_mem_we, b_cpu_rst_n, b_busy, b_done, b_err;
  logic [ADDR_W-1:0] b_mem_addr;
  logic [31:0]       b_mem_wdata;
  logic [ADDR_W:0]   b_words_loaded;

  int errors = 0;
  int checks = 0;

  // Write monitor state
  int                we_cycles;
  int                overlap_bad;
  int                stable_bad;
  int                stall;
  logic              prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .BOOT_RUN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .BOOT_RUN(1'b1)) u_boot (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_ready(mem_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_rst_n(b_cpu_rst_n),
    .busy(b_busy), .done(b_done), .err(b_err), .words_loaded(b_words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int waited;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (1) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Send n bytes from a packed vector, most significant byte first.
  task automatic send_bytes(input int n, input logic [63:0] bytes);
    for (int i = n - 1; i >= 0; i--) send_byte(bytes[8*i +: 8]);
  endtask

  task automatic clear_monitor();
    wr_addr.delete();
    wr_data.delete();
    we_cycles   = 0;
    overlap_bad = 0;
    stable_bad  = 0;
  endtask

  // RAM model: stalls the first `stall` write cycles, logs accepted writes.
  initial begin
    mem_ready = 1'b1;
    prev_we   = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        we_cycles++;
        if (in_ready) overlap_bad++;
        if (prev_we && (mem_addr != prev_addr || mem_wdata != prev_data)) stable_bad++;
        if (stall > 0) begin
          mem_ready = 1'b0;
          stall--;
        end else begin
          mem_ready = 1'b1;
        end
        if (mem_ready) begin
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_wdata);
        end
      end else begin
        mem_ready = 1'b1;
      end
      prev_we   = mem_we;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stall    = 0;
    clear_monitor();
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("boot_cpu_rst_n", 32'(b_cpu_rst_n), 1);

    // T1: single word, no stall
    clear_monitor();
    send_byte(8'hA5);
    check("t1_busy_after_sync", 32'(busy), 1);
    send_bytes(7, 64'h01_00_13_00_00_00_ED);
    tick(3);
    check("t1_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t1_addr", 32'(wr_addr[0]), 0);
      check("t1_data", wr_data[0], 32'h00000013);
    end
    check("t1_we_cycles", we_cycles, 1);
    check("t1_done", 32'(done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("t1_words", 32'(words_loaded), 1);
    check("t1_busy", 32'(busy), 0);

    // T2: two words, first write stalled 3 cycles
    clear_monitor();
    stall = 3;
    send_bytes(3, 64'hA5_02_00);
    check("t2_cpu_rst_n_low", 32'(cpu_rst_n), 0);
    send_bytes(8, 64'h44_33_22_11_DD_CC_BB_AA);
    send_byte(8'h48);
    tick(3);
    check("t2_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t2_addr0", 32'(wr_addr[0]), 0);
      check("t2_data0", wr_data[0], 32'h11223344);
      check("t2_addr1", 32'(wr_addr[1]), 1);
      check("t2_data1", wr_data[1], 32'hAABBCCDD);
    end
    check("t2_we_cycles", we_cycles, 5);
    check("t2_ready_during_we", overlap_bad, 0);
    check("t2_unstable_write", stable_bad, 0);
    check("t2_done", 32'(done), 1);
    check("t2_words", 32'(words_loaded), 2);
    check("t2_mem_addr", 32'(mem_addr), 2);

    // T3: bad checksum, then a good frame
    clear_monitor();
    send_bytes(8, 64'hA5_01_00_13_00_00_00_00);
    tick(3);
    check("t3_err", 32'(err), 1);
    check("t3_done", 32'(done), 0);
    check("t3_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("t3_busy", 32'(busy), 0);
    send_bytes(8, 64'hA5_01_00_13_00_00_00_ED);
    tick(3);
    check("t3_recover_err", 32'(err), 0);
    check("t3_recover_done", 32'(done), 1);
    check("t3_recover_cpu", 32'(cpu_rst_n), 1);

    // T4: count 0 and count 4097 rejected without writes
    clear_monitor();
    send_bytes(3, 64'hA5_00_00);
    tick(1);
    check("t4_cnt0_err", 32'(err), 1);
    check("t4_cnt0_busy", 32'(busy), 0);
    send_byte(8'hA5);
    check("t4_resync_err", 32'(err), 0);
    check("t4_resync_busy", 32'(busy), 1);
    send_bytes(2, 64'h01_10);
    tick(1);
    check("t4_cnt4097_err", 32'(err), 1);
    check("t4_cnt4097_busy", 32'(busy), 0);
    check("t4_nwrites", wr_addr.size(), 0);

    // T4b: count 4096 is legal; reset while the first write is pending
    stall = 100;
    send_bytes(3, 64'hA5_00_10);
    check("t4_cnt4096_busy", 32'(busy), 1);
    check("t4_cnt4096_err", 32'(err), 0);
    send_bytes(4, 64'h01_02_03_04);
    check("rst_mid_we_pre", 32'(mem_we), 1);
    check("rst_mid_data_pre", mem_wdata, 32'h04030201);
    rst = 1'b1;
    tick(1);
    check("rst_mid_we", 32'(mem_we), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_words", 32'(words_loaded), 0);
    check("rst_mid_cpu", 32'(cpu_rst_n), 0);
    check("rst_mid_boot_cpu", 32'(b_cpu_rst_n), 1);
    check("rst_mid_boot_we", 32'(b_mem_we), 0);
    rst   = 1'b0;
    stall = 0;
    tick(1);

    // T5: garbage ignored, A5 as payload, A5 in RUN restarts
    clear_monitor();
    send_bytes(3, 64'h00_FF_12);
    check("t5_garbage_busy", 32'(busy), 0);
    send_bytes(8, 64'hA5_01_00_A5_00_00_00_5B);
    tick(3);
    check("t5_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t5_data", wr_data[0], 32'h000000A5);
    end
    check("t5_done", 32'(done), 1);
    check("t5_cpu_rst_n", 32'(cpu_rst_n), 1);
    send_byte(8'hA5);
    check("t5_run_sync_cpu", 32'(cpu_rst_n), 0);
    check("t5_run_sync_done", 32'(done), 0);
    check("t5_run_sync_words", 32'(words_loaded), 0);
    check("t5_run_sync_addr", 32'(mem_addr), 0);
    clear_monitor();
    send_bytes(7, 64'h01_00_13_00_00_00_ED);
    tick(3);
    check("t5_restart_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t5_restart_addr", 32'(wr_addr[0]), 0);
    end
    check("t5_restart_done", 32'(done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
